riv_cdc_handshake_rx: RTL and testbench

Destination-side endpoint of a toggle-based req/ack multi-bit CDC handshake. The source domain holds a data word stable and toggles src_req_tgl. This block synchronizes the request, captures the word, and presents it on a dst_clk valid/ready interface. It toggles dst_ack_tgl back to the source only after the word is consumed, which gives end-to-end backpressure. It sits at every multi-bit control/status crossing into a dst_clk domain; the matching source-side transmitter owns the opposite end.

---
 rtl/riv_cdc_hs_pkg.sv | 8 +
 rtl/riv_synchronizer_2ff.sv | 20 ++
 rtl/riv_cdc_handshake_rx.sv | 69 ++++++
 tb/tb_riv_cdc_handshake_rx.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/riv_cdc_hs_pkg.sv
// Shared types and constants for the toggle req/ack CDC handshake endpoints.
package riv_cdc_hs_pkg;

  typedef enum logic {HS_IDLE = 1'b0, HS_FULL = 1'b1} hs_rx_state_t;

  localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/riv_synchronizer_2ff.sv
// Single-bit multi-flop synchronizer with async active-low reset to 0.
module riv_synchronizer_2ff #(
  parameter int STAGES = 2
) (
  input  logic src_in,
  input  logic dst_clk,
  input  logic dst_rst_n,
  output logic dst_out
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge dst_clk or negedge dst_rst_n) begin
    if (!dst_rst_n) sync_q <= '0;
    else            sync_q <= {sync_q[STAGES-2:0], src_in};
  end

  assign dst_out = sync_q[STAGES-1];

endmodule

// File: rtl/riv_cdc_handshake_rx.sv
// Destination endpoint of a toggle req/ack CDC handshake: captures one word
// per round trip and acks only once it has been consumed downstream.
module riv_cdc_handshake_rx
  import riv_cdc_hs_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              dst_clk,
  input  logic              dst_rst_n,
  input  logic              src_req_tgl,
  input  logic [DATA_W-1:0] src_data,
  output logic              dst_ack_tgl,
  output logic              dst_valid,
  input  logic              dst_ready,
  output logic [DATA_W-1:0] dst_data,
  output logic [CNT_W-1:0]  dst_xfer_cnt,
  output logic              dst_proto_err
);

  hs_rx_state_t state;
  logic         req_sync;
  logic         req_seen;
  logic         new_req;

  riv_synchronizer_2ff #(.STAGES(SYNC_STAGES)) u_req_sync (
    .src_in    (src_req_tgl),
    .dst_clk   (dst_clk),
    .dst_rst_n (dst_rst_n),
    .dst_out   (req_sync)
  );

  assign new_req   = req_sync ^ req_seen;
  assign dst_valid = (state == HS_FULL);

  // src_data is sampled unsynchronized: by the capture edge it has been
  // stable for at least two dst_clk edges and stays so until ack returns.
  always_ff @(posedge dst_clk or negedge dst_rst_n) begin
    if (!dst_rst_n) begin
      state         <= HS_IDLE;
      req_seen      <= 1'b0;
      dst_data      <= '0;
      dst_ack_tgl   <= 1'b0;
      dst_xfer_cnt  <= '0;
      dst_proto_err <= 1'b0;
    end else begin
      case (state)
        HS_IDLE: begin
          if (new_req) begin
            dst_data <= src_data;
            req_seen <= req_sync;
            state    <= HS_FULL;
          end
        end
        HS_FULL: begin
          // Source toggled again before seeing ack: flag only, not captured.
          if (new_req) dst_proto_err <= 1'b1;
          if (dst_ready) begin
            dst_ack_tgl  <= ~dst_ack_tgl;
            dst_xfer_cnt <= dst_xfer_cnt + 1'b1;
            state        <= HS_IDLE;
          end
        end
        default: state <= HS_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_riv_cdc_handshake_rx.sv
// Directed bench for riv_cdc_handshake_rx: latency, backpressure, streaming,
// protocol error, reset mid-transfer and counter wrap (second instance).
module tb_riv_cdc_handshake_rx;

  logic        dst_clk = 1'b0;
  logic        src_clk = 1'b0;
  logic        dst_rst_n = 1'b0;
  logic        src_req_tgl = 1'b0;
  logic [31:0] src_data = '0;
  logic        man_ready = 1'b0;
  logic        rnd_ready = 1'b0;
  logic        stream_on = 1'b0;
  logic        dst_ready;
  logic        dst_ack_tgl, dst_valid, dst_proto_err;
  logic [31:0] dst_data;
  logic [15:0] dst_xfer_cnt;

  logic        w_req = 1'b0;
  logic [7:0]  w_data = '0;
  logic        w_ready = 1'b1;
  logic        w_ack, w_valid, w_err;
  logic [7:0]  w_dout;
  logic [1:0]  w_cnt;

  logic [1:0]  ack_s = '0;
  logic [31:0] got_q[$];
  logic [31:0] words[100];

  int checks = 0;
  int failures = 0;

  assign dst_ready = stream_on ? rnd_ready : man_ready;

  riv_cdc_handshake_rx #(.DATA_W(32), .CNT_W(16)) dut (
    .dst_clk(dst_clk), .dst_rst_n(dst_rst_n), .src_req_tgl(src_req_tgl),
    .src_data(src_data), .dst_ack_tgl(dst_ack_tgl), .dst_valid(dst_valid),
    .dst_ready(dst_ready), .dst_data(dst_data), .dst_xfer_cnt(dst_xfer_cnt),
    .dst_proto_err(dst_proto_err)
  );

  riv_cdc_handshake_rx #(.DATA_W(8), .CNT_W(2)) dut_w (
    .dst_clk(dst_clk), .dst_rst_n(dst_rst_n), .src_req_tgl(w_req),
    .src_data(w_data), .dst_ack_tgl(w_ack), .dst_valid(w_valid),
    .dst_ready(w_ready), .dst_data(w_dout), .dst_xfer_cnt(w_cnt),
    .dst_proto_err(w_err)
  );

  always #5 dst_clk = ~dst_clk;
  always #3 src_clk = ~src_clk;

  always @(posedge src_clk) ack_s <= {ack_s[0], dst_ack_tgl};

  // Random sink: a word is taken when valid is seen with the ready we drive.
  always @(negedge dst_clk) begin
    if (stream_on) begin
      logic r;
      r = 1'($urandom_range(0, 1));
      rnd_ready = r;
      if (dst_valid && r) got_q.push_back(dst_data);
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    man_ready   = 1'b0;
    src_req_tgl = 1'b0;
    @(negedge dst_clk);
    dst_rst_n = 1'b0;
    repeat (2) @(negedge dst_clk);
    dst_rst_n = 1'b1;
    @(negedge dst_clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    int n;
    int tmo;
    logic [1:0] exp_cnt[5];
    exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

    repeat (2) @(negedge dst_clk);
    chk("rst_valid", 64'(dst_valid), 64'd0);
    chk("rst_ack",   64'(dst_ack_tgl), 64'd0);
    chk("rst_data",  64'(dst_data), 64'd0);
    chk("rst_cnt",   64'(dst_xfer_cnt), 64'd0);
    chk("rst_err",   64'(dst_proto_err), 64'd0);
    dst_rst_n = 1'b1;
    @(negedge dst_clk);

    // Single transfer, ready held high
    man_ready = 1'b1;
    src_data = 32'hDEADBEEF;
    src_req_tgl = 1'b1;
    @(negedge dst_clk); chk("t1_e0_valid", 64'(dst_valid), 64'd0);
    @(negedge dst_clk); chk("t1_e1_valid", 64'(dst_valid), 64'd0);
    @(negedge dst_clk);
    chk("t1_e2_valid", 64'(dst_valid), 64'd1);
    chk("t1_e2_data",  64'(dst_data), 64'hDEADBEEF);
    chk("t1_e2_ack",   64'(dst_ack_tgl), 64'd0);
    @(negedge dst_clk);
    chk("t1_e3_valid", 64'(dst_valid), 64'd0);
    chk("t1_e3_ack",   64'(dst_ack_tgl), 64'd1);
    chk("t1_e3_cnt",   64'(dst_xfer_cnt), 64'd1);

    // Backpressure for 10 cycles
    man_ready = 1'b0;
    src_data = 32'hCAFEF00D;
    src_req_tgl = 1'b0;
    repeat (3) @(negedge dst_clk);
    chk("t2_valid", 64'(dst_valid), 64'd1);
    bad = 0;
    repeat (10) begin
      @(negedge dst_clk);
      if (!(dst_valid === 1'b1 && dst_data === 32'hCAFEF00D && dst_ack_tgl === 1'b1)) bad++;
    end
    chk("t2_hold", 64'(bad), 64'd0);
    man_ready = 1'b1;
    @(negedge dst_clk);
    chk("t2_valid_drop", 64'(dst_valid), 64'd0);
    chk("t2_ack",        64'(dst_ack_tgl), 64'd0);
    chk("t2_cnt",        64'(dst_xfer_cnt), 64'd2);

    // Stream of 100 words, source waits for synchronized ack
    do_reset();
    stream_on = 1'b1;
    tmo = 0;
    for (int i = 0; i < 100; i++) begin
      words[i] = $urandom;
      @(negedge src_clk);
      src_data = words[i];
      src_req_tgl = ~src_req_tgl;
      n = 0;
      while (ack_s[1] !== src_req_tgl && n < 200) begin
        @(negedge src_clk);
        n++;
      end
      if (n >= 200) tmo++;
    end
    repeat (10) @(negedge dst_clk);
    stream_on = 1'b0;
    chk("t3_timeouts", 64'(tmo), 64'd0);
    chk("t3_count", 64'(got_q.size()), 64'd100);
    bad = 0;
    for (int i = 0; i < 100; i++)
      if (i >= got_q.size() || got_q[i] !== words[i]) bad++;
    chk("t3_order", 64'(bad), 64'd0);
    chk("t3_cnt", 64'(dst_xfer_cnt), 64'd100);
    chk("t3_err", 64'(dst_proto_err), 64'd0);

    // Second toggle while FULL
    do_reset();
    src_data = 32'h11111111;
    src_req_tgl = 1'b1;
    repeat (3) @(negedge dst_clk);
    chk("t4_valid", 64'(dst_valid), 64'd1);
    src_data = 32'h22222222;
    src_req_tgl = 1'b0;
    repeat (3) @(negedge dst_clk);
    chk("t4_err",   64'(dst_proto_err), 64'd1);
    chk("t4_data",  64'(dst_data), 64'h11111111);
    chk("t4_ack0",  64'(dst_ack_tgl), 64'd0);
    man_ready = 1'b1;
    @(negedge dst_clk);
    chk("t4_ack1",  64'(dst_ack_tgl), 64'd1);
    chk("t4_cnt",   64'(dst_xfer_cnt), 64'd1);
    man_ready = 1'b0;
    repeat (5) @(negedge dst_clk);
    chk("t4_ack_once",   64'(dst_ack_tgl), 64'd1);
    chk("t4_err_sticky", 64'(dst_proto_err), 64'd1);

    // Reset while FULL, source left at req=1
    src_data = 32'h33333333;
    src_req_tgl = 1'b1;
    #2 dst_rst_n = 1'b0;
    #1;
    chk("t5_valid", 64'(dst_valid), 64'd0);
    chk("t5_ack",   64'(dst_ack_tgl), 64'd0);
    chk("t5_data",  64'(dst_data), 64'd0);
    chk("t5_cnt",   64'(dst_xfer_cnt), 64'd0);
    chk("t5_err",   64'(dst_proto_err), 64'd0);
    @(negedge dst_clk);
    man_ready = 1'b1;
    dst_rst_n = 1'b1;
    repeat (3) @(negedge dst_clk);
    chk("t5_redeliver_valid", 64'(dst_valid), 64'd1);
    chk("t5_redeliver_data",  64'(dst_data), 64'h33333333);
    @(negedge dst_clk);
    chk("t5_ack_tgl", 64'(dst_ack_tgl), 64'd1);
    chk("t5_cnt1",    64'(dst_xfer_cnt), 64'd1);

    // Counter wrap on the CNT_W=2 instance
    for (int i = 0; i < 5; i++) begin
      w_data = 8'(i + 1);
      w_req = ~w_req;
      repeat (4) @(negedge dst_clk);
      chk($sformatf("t6_cnt%0d", i), 64'(w_cnt), 64'(exp_cnt[i]));
      chk($sformatf("t6_data%0d", i), 64'(w_dout), 64'(i + 1));
    end
    chk("t6_err", 64'(w_err), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
